// File: rtl/auth_init_pkg.sv
// rtl/auth_init_pkg.sv - shared types and constants for the authentication request scheduler
package auth_init_pkg;

  localparam int HDR_W     = 32;
  localparam int PAYLOAD_W = 32;

  localparam logic [7:0] PROTOCOL_VERSION = 8'h01;
  localparam logic [7:0] MT_DIGESTS       = 8'h81;
  localparam logic [7:0] MT_GET_CERT      = 8'h82;
  localparam logic [7:0] MT_CHALLENGE     = 8'h83;

  typedef enum logic [1:0] {
    REQ_INVALID   = 2'd0,
    REQ_CHALLENGE = 2'd1,
    REQ_DIGESTS   = 2'd2,
    REQ_CERT      = 2'd3
  } req_type_e;

  typedef enum logic [1:0] {
    FAIL_NONE      = 2'd0,
    FAIL_INVALID   = 2'd1,
    FAIL_RSP_ERROR = 2'd2,
    FAIL_TIMEOUT   = 2'd3
  } fail_code_e;

  typedef enum logic [6:0] {
    ST_IDLE       = 7'b0000001,
    ST_BUILD      = 7'b0000010,
    ST_SEND       = 7'b0000100,
    ST_WAIT_RSP   = 7'b0001000,
    ST_NEXT_CHUNK = 7'b0010000,
    ST_DONE       = 7'b0100000,
    ST_FAIL       = 7'b1000000
  } state_e;

  // Wire MessageType for a request kind; invalid kinds never reach BUILD.
  function automatic logic [7:0] msg_type(input req_type_e t);
    case (t)
      REQ_DIGESTS:   return MT_DIGESTS;
      REQ_CERT:      return MT_GET_CERT;
      REQ_CHALLENGE: return MT_CHALLENGE;
      default:       return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/auth_timeout_timer.sv
// rtl/auth_timeout_timer.sv - loadable down-counter that flags expiry while enabled
module auth_timeout_timer #(
  parameter int unsigned TIMEOUT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] load_value,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] count;

  // Load wins over counting; the counter parks at zero until reloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = enable && (count == '0);

endmodule

// File: rtl/auth_request_scheduler.sv
// rtl/auth_request_scheduler.sv - authentication request initiator; AUTH_INIT_RETRY_EN enables timeout re-sends
module auth_request_scheduler
  import auth_init_pkg::*;
#(
  parameter int unsigned          NUM_SLOTS    = 4,
  parameter logic [15:0]          CERT_CHUNK   = 16'd64,
  parameter int unsigned          TIMEOUT_W    = 32,
  parameter logic [TIMEOUT_W-1:0] TO_DIGESTS   = 32'd2000,
  parameter logic [TIMEOUT_W-1:0] TO_CHALLENGE = 32'd4000,
  parameter logic [TIMEOUT_W-1:0] TO_CERT      = 32'd3000,
`ifdef AUTH_INIT_RETRY_EN
  parameter int unsigned          MAX_RETRIES  = 2,
`endif
  localparam int unsigned         SLOT_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_type,
  input  logic [SLOT_W-1:0]    req_slot,
  output logic                 msg_valid,
  input  logic                 msg_ready,
  output logic [HDR_W-1:0]     header,
  output logic [PAYLOAD_W-1:0] payload,
  input  logic                 rsp_valid,
  input  logic                 rsp_error,
  input  logic [15:0]          rsp_remain,
  output logic                 done,
  output logic                 fail,
  output logic [1:0]           fail_code,
  output logic                 busy
);

  state_e               state, state_d;
  req_type_e            type_q;
  logic [SLOT_W-1:0]    slot_q;
  logic [15:0]          offset_q;
  logic [15:0]          offset_sum;
  fail_code_e           fail_code_q, fail_code_d;
  logic                 slot_oob;
  logic                 timer_load;
  logic                 timer_expired;
  logic                 retry_ok;
  logic [TIMEOUT_W-1:0] timeout_value;

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign msg_valid  = (state == ST_SEND);
  assign fail_code  = fail_code_q;
  assign slot_oob   = (32'(req_slot) >= NUM_SLOTS);
  assign offset_sum = offset_q + CERT_CHUNK;
  assign timer_load = (state == ST_SEND) && msg_ready;

  // Each request kind has its own response deadline.
  always_comb begin
    timeout_value = TO_DIGESTS;
    case (type_q)
      REQ_CHALLENGE: timeout_value = TO_CHALLENGE;
      REQ_CERT:      timeout_value = TO_CERT;
      default:       timeout_value = TO_DIGESTS;
    endcase
  end

  auth_timeout_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .enable     (state == ST_WAIT_RSP),
    .load_value (timeout_value),
    .expired    (timer_expired)
  );

`ifdef AUTH_INIT_RETRY_EN
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RETRY_W-1:0] retry_q;

  assign retry_ok = (32'(retry_q) < MAX_RETRIES);

  // Re-send budget restarts for every new request and every new certificate chunk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_q <= '0;
    end else if (((state == ST_IDLE) && req_valid) || (state == ST_NEXT_CHUNK)) begin
      retry_q <= '0;
    end else if ((state == ST_WAIT_RSP) && !rsp_valid && timer_expired && retry_ok) begin
      retry_q <= retry_q + 1'b1;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  // Next-state and failure-cause selection; a reply beats a same-cycle expiry.
  always_comb begin
    state_d     = state;
    fail_code_d = fail_code_q;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          fail_code_d = FAIL_NONE;
          if ((req_type == REQ_INVALID) || slot_oob) begin
            fail_code_d = FAIL_INVALID;
            state_d     = ST_FAIL;
          end else begin
            state_d = ST_BUILD;
          end
        end
      end
      ST_BUILD: state_d = ST_SEND;
      ST_SEND: begin
        if (msg_ready) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (rsp_valid) begin
          if (rsp_error) begin
            fail_code_d = FAIL_RSP_ERROR;
            state_d     = ST_FAIL;
          end else if ((type_q == REQ_CERT) && (rsp_remain != 16'd0)) begin
            state_d = ST_NEXT_CHUNK;
          end else begin
            state_d = ST_DONE;
          end
        end else if (timer_expired) begin
          if (retry_ok) begin
            state_d = ST_SEND;
          end else begin
            fail_code_d = FAIL_TIMEOUT;
            state_d     = ST_FAIL;
          end
        end
      end
      ST_NEXT_CHUNK: begin
        if (offset_sum == 16'd0) begin
          fail_code_d = FAIL_TIMEOUT;
          state_d     = ST_FAIL;
        end else begin
          state_d = ST_BUILD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Request context, message image and completion pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_q      <= REQ_INVALID;
      slot_q      <= '0;
      offset_q    <= '0;
      header      <= '0;
      payload     <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_code_q <= FAIL_NONE;
    end else begin
      done        <= (state == ST_DONE);
      fail        <= (state == ST_FAIL);
      fail_code_q <= fail_code_d;
      if ((state == ST_IDLE) && req_valid) begin
        type_q   <= req_type_e'(req_type);
        slot_q   <= req_slot;
        offset_q <= '0;
      end
      if (state == ST_BUILD) begin
        header  <= {PROTOCOL_VERSION, msg_type(type_q), 8'(slot_q), 8'h00};
        payload <= (type_q == REQ_CERT) ? {offset_q, CERT_CHUNK} : '0;
      end
      if (state == ST_NEXT_CHUNK) offset_q <= offset_sum;
    end
  end

endmodule

// File: tb/tb_auth_request_scheduler.sv
// tb/tb_auth_request_scheduler.sv - directed self-checking bench for auth_request_scheduler
module tb_auth_request_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_type = 2'd0;
  logic [1:0]  req_slot = 2'd0;
  logic        msg_valid;
  logic        msg_ready = 1'b1;
  logic [31:0] header;
  logic [31:0] payload;
  logic        rsp_valid = 1'b0;
  logic        rsp_error = 1'b0;
  logic [15:0] rsp_remain = 16'd0;
  logic        done;
  logic        fail;
  logic [1:0]  fail_code;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cycle_now = 0;
  int t0 = 0;
  int lat;
  int send_cnt = 0;
  int done_cnt = 0;
  int fail_cnt = 0;
  logic [31:0] hdr_q[$];
  logic [31:0] pay_q[$];
  logic [15:0] remain_tab [3] = '{16'd128, 16'd64, 16'd0};
  logic [31:0] pay_exp [3] = '{32'h00000040, 32'h00400040, 32'h00800040};

  always #5 clk = ~clk;

  auth_request_scheduler #(
    .NUM_SLOTS    (3),
    .CERT_CHUNK   (16'd64),
    .TIMEOUT_W    (32),
    .TO_DIGESTS   (32'd50),
    .TO_CHALLENGE (32'd20),
    .TO_CERT      (32'd40)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_type   (req_type),
    .req_slot   (req_slot),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .header     (header),
    .payload    (payload),
    .rsp_valid  (rsp_valid),
    .rsp_error  (rsp_error),
    .rsp_remain (rsp_remain),
    .done       (done),
    .fail       (fail),
    .fail_code  (fail_code),
    .busy       (busy)
  );

  always @(posedge clk) cycle_now = cycle_now + 1;

  // Handshake and pulse monitor, sampling mid-cycle.
  always begin
    @(negedge clk);
    #1;
    if (msg_valid && msg_ready) begin
      send_cnt++;
      hdr_q.push_back(header);
      pay_q.push_back(payload);
    end
    if (done) done_cnt++;
    if (fail) fail_cnt++;
  end

  function automatic logic [31:0] get_hdr(input int i);
    return (hdr_q.size() > i) ? hdr_q[i] : 32'hFFFFFFFF;
  endfunction

  function automatic logic [31:0] get_pay(input int i);
    return (pay_q.size() > i) ? pay_q[i] : 32'hFFFFFFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    send_cnt = 0;
    done_cnt = 0;
    fail_cnt = 0;
    hdr_q.delete();
    pay_q.delete();
  endtask

  task automatic start_req(input logic [1:0] t, input logic [1:0] s);
    clear_mon();
    @(negedge clk);
    req_valid = 1'b1;
    req_type  = t;
    req_slot  = s;
    t0        = cycle_now;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_until(input int k);
    while ((cycle_now - t0) < k) @(negedge clk);
  endtask

  task automatic wait_end(input int max_cyc, output int l);
    while (!(done || fail) && ((cycle_now - t0) < max_cyc)) @(negedge clk);
    l = cycle_now - t0;
    check("end_seen", 32'(done || fail), 32'd1);
  endtask

  task automatic wait_sends(input int n, input int max_cyc);
    while ((send_cnt < n) && ((cycle_now - t0) < max_cyc)) @(negedge clk);
    check("send_seen", 32'(send_cnt), 32'(n));
  endtask

  task automatic pulse_rsp(input logic err, input logic [15:0] remain);
    rsp_valid  = 1'b1;
    rsp_error  = err;
    rsp_remain = remain;
    @(negedge clk);
    rsp_valid  = 1'b0;
    rsp_error  = 1'b0;
    rsp_remain = 16'd0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_msg_valid", 32'(msg_valid), 32'd0);
    check("rst_pulses", 32'({done, fail}), 32'd0);
    check("rst_fail_code", 32'(fail_code), 32'd0);
    check("rst_header", header, 32'd0);
    reset = 1'b0;

    // Stray reply while idle must not start anything.
    clear_mon();
    @(negedge clk);
    pulse_rsp(1'b0, 16'd0);
    @(negedge clk);
    check("idle_rsp_busy", 32'(busy), 32'd0);
    check("idle_rsp_pulses", 32'(done_cnt + fail_cnt), 32'd0);

    // DIGESTS slot 2, reply at cycle 10.
    start_req(2'd2, 2'd2);
    check("dig_busy", 32'(busy), 32'd1);
    check("dig_req_ready", 32'(req_ready), 32'd0);
    wait_until(10);
    pulse_rsp(1'b0, 16'd0);
    wait_end(40, lat);
    check("dig_latency", 32'(lat), 32'd12);
    check("dig_done", 32'(done), 32'd1);
    check("dig_fail_code", 32'(fail_code), 32'd0);
    check("dig_sends", 32'(send_cnt), 32'd1);
    check("dig_header", get_hdr(0), 32'h01810200);
    check("dig_payload", get_pay(0), 32'h00000000);
    repeat (2) @(negedge clk);
    check("dig_done_once", 32'(done_cnt), 32'd1);
    check("dig_no_fail", 32'(fail_cnt), 32'd0);

    // CERTIFICATE slot 1 in three chunks.
    start_req(2'd3, 2'd1);
    for (int i = 0; i < 3; i++) begin
      wait_sends(i + 1, 200);
      repeat (2) @(negedge clk);
      pulse_rsp(1'b0, remain_tab[i]);
    end
    wait_end(300, lat);
    check("cert_done", 32'(done), 32'd1);
    check("cert_sends", 32'(send_cnt), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("cert_header", get_hdr(i), 32'h01820100);
      check("cert_payload", get_pay(i), pay_exp[i]);
    end
    repeat (2) @(negedge clk);
    check("cert_done_once", 32'(done_cnt), 32'd1);
    check("cert_no_fail", 32'(fail_cnt), 32'd0);

    // CHALLENGE slot 0 with no reply.
    start_req(2'd1, 2'd0);
    wait_end(200, lat);
    check("chal_fail", 32'(fail), 32'd1);
    check("chal_fail_code", 32'(fail_code), 32'd3);
    check("chal_header", get_hdr(0), 32'h01830000);
`ifdef AUTH_INIT_RETRY_EN
    check("chal_latency", 32'(lat), 32'd69);
    check("chal_sends", 32'(send_cnt), 32'd3);
`else
    check("chal_latency", 32'(lat), 32'd25);
    check("chal_sends", 32'(send_cnt), 32'd1);
`endif
    repeat (3) @(negedge clk);
    check("chal_code_held", 32'(fail_code), 32'd3);
    check("chal_no_done", 32'(done_cnt), 32'd0);

    // Error reply in the very cycle the timer expires.
    start_req(2'd1, 2'd0);
    check("err_code_cleared", 32'(fail_code), 32'd0);
    wait_until(23);
    pulse_rsp(1'b1, 16'd0);
    wait_end(60, lat);
    check("err_latency", 32'(lat), 32'd25);
    check("err_fail_code", 32'(fail_code), 32'd2);

    // Invalid request type.
    start_req(2'd0, 2'd0);
    wait_end(10, lat);
    check("inv_type_latency", 32'(lat), 32'd2);
    check("inv_type_code", 32'(fail_code), 32'd1);
    @(negedge clk);
    check("inv_type_sends", 32'(send_cnt), 32'd0);

    // Slot index equal to NUM_SLOTS.
    start_req(2'd2, 2'd3);
    wait_end(10, lat);
    check("inv_slot_latency", 32'(lat), 32'd2);
    check("inv_slot_code", 32'(fail_code), 32'd1);
    @(negedge clk);
    check("inv_slot_sends", 32'(send_cnt), 32'd0);

    // Reset while waiting for a reply.
    start_req(2'd2, 2'd0);
    wait_until(6);
    check("rstw_busy_before", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rstw_req_ready", 32'(req_ready), 32'd1);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_msg_valid", 32'(msg_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("rstw_no_pulse", 32'(done_cnt + fail_cnt), 32'd0);
    check("rstw_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
